// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches an active-low multiplexed 7-segment bus and rebuilds per-digit nibbles.
// Defining SEG7_DP_EN adds decimal-point capture (dp in, digit_dp out).
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg,
  input  logic [DIGITS-1:0]         an,
`ifdef SEG7_DP_EN
  input  logic                      dp,
  output logic [DIGITS-1:0]         digit_dp,
`endif
  output logic [4*DIGITS-1:0]       hex_out,
  output logic [DIGITS-1:0]         digit_valid,
  output logic [DIGITS-1:0]         digit_err,
  output logic                      upd_strobe,
  output logic [$clog2(DIGITS)-1:0] upd_index
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = DIGITS + 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic              in_dp;
  logic [PW-1:0]     pat_in;
  logic [PW-1:0]     s_pat;
  logic [6:0]        s_seg;
  logic [DIGITS-1:0] s_an;
  logic [DIGITS-1:0] an_low;
  logic              in_legal;
  logic [CW-1:0]     cnt;
  logic              accepted;
  logic              acc;
  logic [IW-1:0]     s_idx;
  logic              dec_ok;
  logic [3:0]        dec_nib;

`ifdef SEG7_DP_EN
  assign in_dp = dp;
`else
  assign in_dp = 1'b1;
`endif

  // The whole {dp, an, seg} tuple is the debounced pattern.
  assign pat_in = {in_dp, an, seg};
  assign s_seg  = s_pat[6:0];
  assign s_an   = s_pat[DIGITS+6:7];

  assign an_low   = ~an;
  assign in_legal = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
  assign acc      = (cnt == CNT_MAX) && !accepted;

  always_comb begin
    s_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!s_an[i]) s_idx = IW'(i);
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (s_seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_pat       <= '0;
      cnt         <= '0;
      accepted    <= 1'b0;
      hex_out     <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      upd_strobe  <= 1'b0;
      upd_index   <= '0;
`ifdef SEG7_DP_EN
      digit_dp    <= '0;
`endif
    end else begin
      s_pat      <= pat_in;
      upd_strobe <= 1'b0;
      if (!in_legal) begin
        cnt      <= '0;
        accepted <= 1'b0;
      end else if (pat_in != s_pat) begin
        cnt      <= CW'(1);
        accepted <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (acc) accepted <= 1'b1;
      end
      // Decode uses the registered pattern that has just completed its stable run.
      if (acc) begin
        upd_strobe <= 1'b1;
        upd_index  <= s_idx;
        if (s_seg == 7'h7F) begin
          digit_valid[s_idx] <= 1'b0;
          digit_err[s_idx]   <= 1'b0;
        end else if (dec_ok) begin
          hex_out[4*int'(s_idx) +: 4] <= dec_nib;
          digit_valid[s_idx]          <= 1'b1;
          digit_err[s_idx]            <= 1'b0;
        end else begin
          digit_valid[s_idx] <= 1'b0;
          digit_err[s_idx]   <= 1'b1;
        end
`ifdef SEG7_DP_EN
        digit_dp[s_idx] <= ~s_pat[PW-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed vector table, reset/DP sequences and random
// bus traffic checked every cycle against a run-length reference model.
module tb_seg7_scan_decoder;
  localparam int S = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic        dp  = 1'b1;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        upd_strobe;
  logic [1:0]  upd_index;
`ifdef SEG7_DP_EN
  logic [3:0]  digit_dp;
`endif

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  // Reference model: outputs plus the length of the current run of identical legal samples.
  logic [3:0] m_hex [4];
  logic       m_valid [4];
  logic       m_err [4];
  logic       m_dp [4];
  logic [6:0] m_last_seg;
  logic [3:0] m_last_an;
  logic       m_last_dp;
  int         m_run;
  logic       m_strobe;
  int         m_idx;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
`ifdef SEG7_DP_EN
    .dp(dp), .digit_dp(digit_dp),
`endif
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_err(digit_err),
    .upd_strobe(upd_strobe), .upd_index(upd_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int glyph_of(input logic [6:0] s);
    for (int n = 0; n < 16; n++)
      if (GLYPH[n] == s) return n;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] s, input logic [3:0] a, input logic d);
    int zeros;
    int g;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_hex[i] = 4'h0; m_valid[i] = 1'b0; m_err[i] = 1'b0; m_dp[i] = 1'b0;
      end
      m_last_seg = '0; m_last_an = '0; m_last_dp = 1'b0;
      m_run = 0; m_strobe = 1'b0; m_idx = 0;
    end else begin
      m_strobe = (m_run == S);
      if (m_strobe) begin
        for (int i = 0; i < 4; i++)
          if (!m_last_an[i]) m_idx = i;
        g = glyph_of(m_last_seg);
        if (m_last_seg == 7'h7F) begin
          m_valid[m_idx] = 1'b0; m_err[m_idx] = 1'b0;
        end else if (g >= 0) begin
          m_hex[m_idx] = 4'(g); m_valid[m_idx] = 1'b1; m_err[m_idx] = 1'b0;
        end else begin
          m_valid[m_idx] = 1'b0; m_err[m_idx] = 1'b1;
        end
        m_dp[m_idx] = ~m_last_dp;
      end
      zeros = 0;
      for (int i = 0; i < 4; i++)
        if (!a[i]) zeros++;
      if (zeros == 1 && s == m_last_seg && a == m_last_an && d == m_last_dp) m_run++;
      else m_run = (zeros == 1) ? 1 : 0;
      m_last_seg = s; m_last_an = a; m_last_dp = d;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] a, input logic r);
    logic [15:0] e_hex;
    logic [3:0]  e_valid, e_err, e_dp;
    seg = s; an = a; rst = r;
    @(posedge clk);
    #1;
    model_edge(r, s, a, dp);
    for (int i = 0; i < 4; i++) begin
      e_hex[4*i +: 4] = m_hex[i];
      e_valid[i] = m_valid[i];
      e_err[i]   = m_err[i];
      e_dp[i]    = m_dp[i];
    end
    if (upd_strobe) strobe_cnt++;
    chk("model hex_out", 32'(hex_out), 32'(e_hex));
    chk("model digit_valid", 32'(digit_valid), 32'(e_valid));
    chk("model digit_err", 32'(digit_err), 32'(e_err));
    chk("model upd_strobe", 32'(upd_strobe), 32'(m_strobe));
    if (m_strobe || r) chk("model upd_index", 32'(upd_index), 32'(m_idx));
`ifdef SEG7_DP_EN
    chk("model digit_dp", 32'(digit_dp), 32'(e_dp));
`else
    if (e_dp != e_dp) chk("model digit_dp", 32'(e_dp), 32'(e_dp));
`endif
  endtask

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    int          hold;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  err;
    int          strobes;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{7'h24, 4'b1110, 10, 16'h0002, 4'b0001, 4'b0000, 1};
    vecs[1]  = '{7'h79, 4'b1110,  8, 16'h0001, 4'b0001, 4'b0000, 1};
    vecs[2]  = '{7'h08, 4'b1101,  8, 16'h00A1, 4'b0011, 4'b0000, 1};
    vecs[3]  = '{7'h0E, 4'b1011,  8, 16'h0FA1, 4'b0111, 4'b0000, 1};
    vecs[4]  = '{7'h40, 4'b0111,  8, 16'h0FA1, 4'b1111, 4'b0000, 1};
    vecs[5]  = '{7'h30, 4'b1101,  3, 16'h0FA1, 4'b1111, 4'b0000, 0};
    vecs[6]  = '{7'h19, 4'b1101,  8, 16'h0F41, 4'b1111, 4'b0000, 1};
    vecs[7]  = '{7'h7F, 4'b1101,  8, 16'h0F41, 4'b1101, 4'b0000, 1};
    vecs[8]  = '{7'h55, 4'b1011,  8, 16'h0F41, 4'b1001, 4'b0100, 1};
    vecs[9]  = '{7'h40, 4'b1001, 20, 16'h0F41, 4'b1001, 4'b0100, 0};
    vecs[10] = '{7'h40, 4'b1111, 20, 16'h0F41, 4'b1001, 4'b0100, 0};
    vecs[11] = '{7'h12, 4'b1011,  8, 16'h0541, 4'b1101, 4'b0000, 1};
    vecs[12] = '{7'h55, 4'b1011,  2, 16'h0541, 4'b1101, 4'b0000, 0};
    vecs[13] = '{7'h12, 4'b1011,  8, 16'h0541, 4'b1101, 4'b0000, 1};

    // Reset with random bus activity.
    for (int c = 0; c < 2; c++) step(7'($urandom), 4'($urandom), 1'b1);
    chk("reset hex_out", 32'(hex_out), 32'h0);
    chk("reset digit_valid", 32'(digit_valid), 32'h0);
    chk("reset digit_err", 32'(digit_err), 32'h0);
    chk("reset upd_strobe", 32'(upd_strobe), 32'h0);
    chk("reset upd_index", 32'(upd_index), 32'h0);

    for (int v = 0; v < 14; v++) begin
      strobe_cnt = 0;
      for (int h = 0; h < vecs[v].hold; h++) step(vecs[v].seg, vecs[v].an, 1'b0);
      chk($sformatf("vec%0d hex_out", v), 32'(hex_out), 32'(vecs[v].hex));
      chk($sformatf("vec%0d digit_valid", v), 32'(digit_valid), 32'(vecs[v].valid));
      chk($sformatf("vec%0d digit_err", v), 32'(digit_err), 32'(vecs[v].err));
      chk($sformatf("vec%0d strobes", v), 32'(strobe_cnt), 32'(vecs[v].strobes));
    end

    // Reset asserted exactly on the edge that would accept.
    for (int h = 0; h < S; h++) step(7'h30, 4'b1110, 1'b0);
    step(7'h30, 4'b1110, 1'b1);
    chk("rst-on-accept hex_out", 32'(hex_out), 32'h0);
    chk("rst-on-accept digit_valid", 32'(digit_valid), 32'h0);
    chk("rst-on-accept upd_strobe", 32'(upd_strobe), 32'h0);
    strobe_cnt = 0;
    for (int h = 0; h < 8; h++) step(7'h30, 4'b1110, 1'b0);
    chk("post-reset hex_out", 32'(hex_out), 32'h0003);
    chk("post-reset digit_valid", 32'(digit_valid), 32'b0001);
    chk("post-reset strobes", 32'(strobe_cnt), 32'd1);

`ifdef SEG7_DP_EN
    dp = 1'b0;
    for (int h = 0; h < 8; h++) step(7'h40, 4'b0111, 1'b0);
    chk("dp digit_dp[3]", 32'(digit_dp[3]), 32'h1);
    chk("dp hex_out[15:12]", 32'(hex_out[15:12]), 32'h0);
    dp = 1'b1;
`endif

    // Random traffic: mostly legal glyphs on one digit, with glitches, gaps and junk.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] s;
      logic [3:0] a;
      int         k;
      int         hold;
      k = int'($urandom_range(0, 9));
      if (k < 7) a = ~(4'b0001 << $urandom_range(0, 3));
      else if (k == 7) a = 4'hF;
      else a = 4'($urandom);
      k = int'($urandom_range(0, 13));
      if (k < 11) s = GLYPH[$urandom_range(0, 15)];
      else if (k == 11) s = 7'h7F;
      else s = 7'($urandom);
`ifdef SEG7_DP_EN
      dp = 1'($urandom);
`endif
      hold = int'($urandom_range(1, 9));
      for (int h = 0; h < hold; h++) step(s, a, ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
